// File: rtl/pipelined_addsub_16bit_pkg.sv
// Shared constants for the pipelined add/sub unit: widths, flag bit
// positions and op encoding.
package pipe_pkg;
  localparam int WORD_W = 16;
  localparam int TAG_W  = 3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/pipelined_addsub_16bit_if.sv
// Operand/result handshake bundle between operand fetch, the add/sub unit
// and writeback. flush travels with it since the same producer drives it.
interface pipelined_addsub_16bit_if #(
  parameter int WIDTH = pipe_pkg::WORD_W,
  parameter int TAG_W = pipe_pkg::TAG_W
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, a, b, op_sub, in_tag, out_ready,
    input  in_ready, out_valid, result, flags, out_tag
  );

  modport slave (
    input  flush, in_valid, a, b, op_sub, in_tag, out_ready,
    output in_ready, out_valid, result, flags, out_tag
  );
endinterface

// File: rtl/pipelined_addsub_16bit_cla.sv
// 8-bit carry-look-ahead adder built from two chained 4-bit CLA blocks.
module carry_look_ahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries expanded from generate/propagate, no ripple inside the nibble
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic c4;

  carry_look_ahead_4bit u_lo (.a(a[3:0]), .b(b[3:0]), .cin(cin), .sum(sum[3:0]), .cout(c4));
  carry_look_ahead_4bit u_hi (.a(a[7:4]), .b(b[7:4]), .cin(c4),  .sum(sum[7:4]), .cout(cout));
endmodule

// File: rtl/pipelined_addsub_16bit.sv
// Two-stage 16-bit add/sub: low byte in stage 1, high byte plus flags in
// stage 2, with valid/ready back-pressure and a synchronous flush.
module pipelined_addsub_16bit #(
  parameter int WIDTH = pipe_pkg::WORD_W,
  parameter int TAG_W = pipe_pkg::TAG_W
) (
  input logic                     clk,
  input logic                     rst_n,
  pipelined_addsub_16bit_if.slave bus
);
  localparam int HW = WIDTH / 2;

  logic             v1, v2;
  logic             ready1, ready2, load1, load2;

  logic [HW-1:0]    lo_r, a_hi_r, bx_hi_r;
  logic             c8_r;
  logic [TAG_W-1:0] tag1_r;

  logic [HW-1:0]    bx_lo, lo_sum, hi_sum;
  logic             lo_cout, hi_cout;
  logic [WIDTH-1:0] bx;

  assign ready2      = !v2 | bus.out_ready;
  assign ready1      = !v1 | ready2;
  assign bus.in_ready = ready1 & !bus.flush;
  assign load1       = bus.in_valid & bus.in_ready;
  assign load2       = v1 & ready2 & !bus.flush;

  // Subtraction is A + ~B + 1; the +1 enters as the low slice carry-in
  assign bx    = bus.b ^ {WIDTH{bus.op_sub == pipe_pkg::OP_SUB}};
  assign bx_lo = bx[HW-1:0];

  cla_8bit u_cla_lo (.a(bus.a[HW-1:0]), .b(bx_lo), .cin(bus.op_sub), .sum(lo_sum), .cout(lo_cout));
  cla_8bit u_cla_hi (.a(a_hi_r), .b(bx_hi_r), .cin(c8_r), .sum(hi_sum), .cout(hi_cout));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (bus.flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (ready1) v1 <= bus.in_valid;
      if (ready2) v2 <= v1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_r    <= '0;
      c8_r    <= 1'b0;
      a_hi_r  <= '0;
      bx_hi_r <= '0;
      tag1_r  <= '0;
    end else if (load1) begin
      lo_r    <= lo_sum;
      c8_r    <= lo_cout;
      a_hi_r  <= bus.a[WIDTH-1:HW];
      bx_hi_r <= bx[WIDTH-1:HW];
      tag1_r  <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result  <= '0;
      bus.flags   <= '0;
      bus.out_tag <= '0;
    end else if (load2) begin
      bus.result                   <= {hi_sum, lo_r};
      bus.out_tag                  <= tag1_r;
      bus.flags[pipe_pkg::FLAG_N]  <= hi_sum[HW-1];
      bus.flags[pipe_pkg::FLAG_Z]  <= ({hi_sum, lo_r} == '0);
      bus.flags[pipe_pkg::FLAG_C]  <= hi_cout;
      bus.flags[pipe_pkg::FLAG_V]  <= (a_hi_r[HW-1] == bx_hi_r[HW-1]) &
                                      (hi_sum[HW-1] != a_hi_r[HW-1]);
    end
  end

  assign bus.out_valid = v2;
endmodule
